// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the writeback path.
// Optional build macro used by the writeback arbiter: WB_FIXED_PRIO_EN.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // Architectural zero register: writes to it are discarded.
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  // One writeback request as presented by a source unit.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// rr_arbiter: purely combinational one-of-N grant selection.
// Default build searches round-robin from ptr, wrapping modulo NUM_REQ.
// With WB_FIXED_PRIO_EN defined the ptr port is removed and the lowest
// requesting index always wins.
module rr_arbiter #(
  parameter  int NUM_REQ = 3,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef WB_FIXED_PRIO_EN
  input  logic [IW-1:0]      ptr,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               grant_valid
);

  logic [IW-1:0] idx;

  // First requester found by the search order gets the one-hot grant.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef WB_FIXED_PRIO_EN
      idx = IW'(k);
`else
      idx = IW'((int'(ptr) + k) % NUM_REQ);
`endif
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port between
// NUM_REQ valid/ready writeback sources. One winner per cycle is registered
// onto wb_en/wb_addr/wb_data; requests to x0 are acknowledged immediately and
// never reach the port. Build macro WB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins, no ptr) instead of round-robin.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32,
  parameter int AW      = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*AW-1:0]   req_addr,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic                    wb_en,
  output logic [AW-1:0]           wb_addr,
  output logic [XLEN-1:0]         wb_data,
  output logic                    stall
);

  import riscv_pkg::*;

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] x0_hit;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               grant_valid;
  logic [AW-1:0]      sel_addr;
  logic [XLEN-1:0]    sel_data;

  // Split valid requests into x0 writes (absorbed) and real writes (arbitrated).
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_classify
    logic addr_zero;
    assign addr_zero   = (req_addr[i*AW +: AW] == AW'(REG_ZERO));
    assign x0_hit[i]   = req_valid[i] &  addr_zero;
    assign eligible[i] = req_valid[i] & ~addr_zero;
  end

`ifdef WB_FIXED_PRIO_EN
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req         (eligible),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );
`else
  logic [IW-1:0] ptr;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req         (eligible),
    .ptr         (ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Round-robin pointer moves one past the winner; it holds when nobody wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

  assign sel_addr = req_addr[grant_idx*AW +: AW];
  assign sel_data = req_data[grant_idx*XLEN +: XLEN];

  // x0 requests and the winner complete now; nothing is accepted during reset.
  assign req_ready = rst ? '0 : (x0_hit | grant);
  assign stall     = ~rst & (|(req_valid & ~req_ready));

  // Write-port register: wb_en follows the grant, addr/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      wb_en <= grant_valid;
      if (grant_valid) begin
        wb_addr <= sel_addr;
        wb_data <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (NUM_REQ=3, XLEN=32, AW=5).
// Round-robin sequences run in the default build; the fixed-priority sequence
// runs when WB_FIXED_PRIO_EN is defined.
module tb_regfile_wb_arbiter;

  import riscv_pkg::*;

  localparam int N = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*5-1:0]  req_addr;
  logic [N*32-1:0] req_data;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [31:0]     wb_data;
  logic            stall;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rf [32];

  regfile_wb_arbiter #(.NUM_REQ(N), .XLEN(32), .AW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  // Register file model fed by the write port, used for the final-value check.
  always @(posedge clk) begin
    if (wb_en && wb_addr != 5'd0) rf[wb_addr] <= wb_data;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic wb_req_t mk(input logic [4:0] a, input logic [31:0] d);
    wb_req_t r;
    r.addr = a;
    r.data = d;
    return r;
  endfunction

  task automatic drive(input int i, input logic v, input wb_req_t r);
    req_valid[i]       = v;
    req_addr[i*5 +: 5] = r.addr;
    req_data[i*32 +: 32] = r.data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = '0;
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;

    // Reset state: nothing accepted, no stall even with a valid request.
    drive(0, 1'b1, mk(5'd1, 32'h1));
    #2;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_wb_en", 32'(wb_en), 32'h0);
    check("rst_wb_addr", 32'(wb_addr), 32'h0);
    check("rst_wb_data", wb_data, 32'h0);
    drive(0, 1'b0, mk(5'd0, 32'h0));
    tick();
    tick();
    rst = 1'b0;

    // Single requester on index 1.
    drive(1, 1'b1, mk(5'd5, 32'hDEADBEEF));
    #1;
    check("single_ready", 32'(req_ready), 32'h2);
    check("single_stall", 32'(stall), 32'h0);
    tick();
    check("single_wb_en", 32'(wb_en), 32'h1);
    check("single_wb_addr", 32'(wb_addr), 32'd5);
    check("single_wb_data", wb_data, 32'hDEADBEEF);
    drive(1, 1'b0, mk(5'd0, 32'h0));
    tick();
    check("single_idle_en", 32'(wb_en), 32'h0);
    check("single_hold_addr", 32'(wb_addr), 32'd5);
    check("single_hold_data", wb_data, 32'hDEADBEEF);

    // x0 request absorbed alongside a real write from index 2.
    drive(0, 1'b1, mk(5'd0, 32'h55));
    drive(2, 1'b1, mk(5'd7, 32'h77));
    #1;
    check("x0_ready", 32'(req_ready), 32'h5);
    check("x0_stall", 32'(stall), 32'h0);
    tick();
    check("x0_wb_en", 32'(wb_en), 32'h1);
    check("x0_wb_addr", 32'(wb_addr), 32'd7);
    check("x0_wb_data", wb_data, 32'h77);
    drive(0, 1'b0, mk(5'd0, 32'h0));
    drive(2, 1'b0, mk(5'd0, 32'h0));
    tick();
    check("x0_idle_en", 32'(wb_en), 32'h0);

`ifndef WB_FIXED_PRIO_EN
    // Round-robin: ptr wrapped to 0 after the grant to index 2.
    for (int i = 0; i < N; i++) drive(i, 1'b1, mk(5'(i + 1), 32'hA0 + 32'(i)));
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_ready", 32'(req_ready), 32'(1 << (k % 3)));
      check("rr_stall", 32'(stall), 32'h1);
      tick();
      check("rr_wb_en", 32'(wb_en), 32'h1);
      check("rr_wb_addr", 32'(wb_addr), 32'((k % 3) + 1));
      check("rr_wb_data", wb_data, 32'hA0 + 32'(k % 3));
    end
    for (int i = 0; i < N; i++) drive(i, 1'b0, mk(5'd0, 32'h0));
    tick();
    check("rr_idle_en", 32'(wb_en), 32'h0);

    // Same-address conflict: grant order 0 then 1, later data final.
    drive(0, 1'b1, mk(5'd3, 32'h11));
    drive(1, 1'b1, mk(5'd3, 32'h22));
    #1;
    check("conf_ready0", 32'(req_ready), 32'h1);
    check("conf_stall0", 32'(stall), 32'h1);
    tick();
    check("conf_wb_addr0", 32'(wb_addr), 32'd3);
    check("conf_wb_data0", wb_data, 32'h11);
    drive(0, 1'b0, mk(5'd0, 32'h0));
    #1;
    check("conf_ready1", 32'(req_ready), 32'h2);
    check("conf_stall1", 32'(stall), 32'h0);
    tick();
    check("conf_wb_en1", 32'(wb_en), 32'h1);
    check("conf_wb_data1", wb_data, 32'h22);
    drive(1, 1'b0, mk(5'd0, 32'h0));
    tick();
    check("conf_x3_final", rf[3], 32'h22);

    // Reset mid-operation while wb_en=1 (ptr=2 -> index 2 wins first).
    drive(0, 1'b1, mk(5'd9, 32'h99));
    drive(2, 1'b1, mk(5'd10, 32'hAA));
    #1;
    check("mid_ready", 32'(req_ready), 32'h4);
    tick();
    check("mid_wb_en", 32'(wb_en), 32'h1);
    check("mid_wb_addr", 32'(wb_addr), 32'd10);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_en", 32'(wb_en), 32'h0);
    check("mid_rst_addr", 32'(wb_addr), 32'h0);
    check("mid_rst_data", wb_data, 32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    check("mid_rst_stall", 32'(stall), 32'h0);
    tick();
    check("mid_rst_hold_en", 32'(wb_en), 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'h1);
    check("post_rst_stall", 32'(stall), 32'h1);
    tick();
    check("post_rst_wb_addr", 32'(wb_addr), 32'd9);
    check("post_rst_wb_data", wb_data, 32'h99);
    drive(0, 1'b0, mk(5'd0, 32'h0));
    drive(2, 1'b0, mk(5'd0, 32'h0));
    tick();
`else
    // Fixed priority: index 0 starves index 2 while it stays valid.
    drive(0, 1'b1, mk(5'd4, 32'h44));
    drive(2, 1'b1, mk(5'd6, 32'h66));
    for (int k = 0; k < 3; k++) begin
      #1;
      check("fp_ready", 32'(req_ready), 32'h1);
      check("fp_stall", 32'(stall), 32'h1);
      tick();
      check("fp_wb_addr", 32'(wb_addr), 32'd4);
    end
    drive(0, 1'b0, mk(5'd0, 32'h0));
    #1;
    check("fp_ready2", 32'(req_ready), 32'h4);
    check("fp_stall2", 32'(stall), 32'h0);
    tick();
    check("fp_wb_en2", 32'(wb_en), 32'h1);
    check("fp_wb_addr2", 32'(wb_addr), 32'd6);
    check("fp_wb_data2", wb_data, 32'h66);
    drive(2, 1'b0, mk(5'd0, 32'h0));
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
